// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Requester indices double as bit positions in the valid/ready vectors.
package grf_wb_arbiter_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      REQ_PIPE = 1'b0,
      REQ_MDU  = 1'b1
   } req_idx_e;

   function automatic logic [1:0] idx_onehot(input req_idx_e idx);
      return (idx == REQ_MDU) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bundle of the writeback requests, register-file write port, bypass and debug counter.
// The slave modport is the arbiter's view; master is the surrounding core.
interface grf_wb_arbiter_if #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CNTW = 16
);

   logic            hold;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [AW-1:0]   req_wa0;
   logic [DW-1:0]   req_wd0;
   logic [AW-1:0]   req_wa1;
   logic [DW-1:0]   req_wd1;
   logic            RegWrite;
   logic [AW-1:0]   WA;
   logic [DW-1:0]   WD;
   logic [AW-1:0]   RA1;
   logic [AW-1:0]   RA2;
   logic            byp_hit1;
   logic            byp_hit2;
   logic [DW-1:0]   byp_data;
   logic [CNTW-1:0] stall_cnt;

   modport slave (
      input  hold, req_valid, req_wa0, req_wd0, req_wa1, req_wd1, RA1, RA2,
      output req_ready, RegWrite, WA, WD, byp_hit1, byp_hit2, byp_data, stall_cnt
   );

   modport master (
      output hold, req_valid, req_wa0, req_wd0, req_wa1, req_wd1, RA1, RA2,
      input  req_ready, RegWrite, WA, WD, byp_hit1, byp_hit2, byp_data, stall_cnt
   );

endinterface

// File: rtl/grf_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-winner pointer.
// Grant is combinational from valid; the pointer only moves on a completed handshake.
module grf_wb_arbiter_rr_arb2
   import grf_wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_hold,
   input  logic [1:0] i_valid,
   output logic [1:0] o_grant
);

   req_idx_e   r_last;
   logic [1:0] w_grant;

   // On a tie the requester that did not win last time is served
   always_comb begin
      w_grant = 2'b00;
      if (!reset && !i_hold) begin
         case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = (r_last == REQ_MDU) ? idx_onehot(REQ_PIPE) : idx_onehot(REQ_MDU);
            default: w_grant = 2'b00;
         endcase
      end
   end

   // Reset to MDU so the pipeline wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= REQ_MDU;
      end else if (|w_grant) begin
         r_last <= w_grant[1] ? REQ_MDU : REQ_PIPE;
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the register-file write port between the W stage and the multi-cycle unit,
// with a one-deep registered output stage, read bypass and a saturating stall counter.
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int AW   = AW_DEF,
   parameter int CNTW = 16
) (
   input logic            clk,
   input logic            reset,
   grf_wb_arbiter_if.slave bus
);

   logic [1:0]      w_grant;
   logic            w_accept;
   logic [AW-1:0]   w_selWa;
   logic [DW-1:0]   w_selWd;
   logic            w_denied;

   logic            r_regWrite;
   logic [AW-1:0]   r_wa;
   logic [DW-1:0]   r_wd;
   logic [CNTW-1:0] r_stallCnt;

   grf_wb_arbiter_rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset   (reset),
      .i_hold  (bus.hold),
      .i_valid (bus.req_valid),
      .o_grant (w_grant)
   );

   assign w_accept = |w_grant;
   assign w_selWa  = w_grant[REQ_MDU] ? bus.req_wa1 : bus.req_wa0;
   assign w_selWd  = w_grant[REQ_MDU] ? bus.req_wd1 : bus.req_wd0;
   assign w_denied = |(bus.req_valid & ~w_grant);

   // Writes to register zero complete the handshake but never enable the register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_regWrite <= 1'b0;
         r_wa       <= '0;
         r_wd       <= '0;
      end else begin
         r_regWrite <= w_accept && (w_selWa != AW'(REG_ZERO));
         if (w_accept) begin
            r_wa <= w_selWa;
            r_wd <= w_selWd;
         end
      end
   end

   // One count per denied cycle regardless of how many requesters were turned away
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stallCnt <= '0;
      end else if (w_denied && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + CNTW'(1);
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.RegWrite  = r_regWrite;
   assign bus.WA        = r_wa;
   assign bus.WD        = r_wd;
   assign bus.stall_cnt = r_stallCnt;

   // Covers the cycle where the write sits in the stage but is not yet in the register file
   assign bus.byp_hit1 = r_regWrite && (r_wa == bus.RA1) && (bus.RA1 != AW'(REG_ZERO));
   assign bus.byp_hit2 = r_regWrite && (r_wa == bus.RA2) && (bus.RA2 != AW'(REG_ZERO));
   assign bus.byp_data = r_wd;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios followed by randomized
// requests, all compared against a cycle-level reference model of the arbitration rules.
module tb_grf_wb_arbiter;

   localparam int DW      = 32;
   localparam int AW      = 5;
   localparam int CNTW    = 4;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   grf_wb_arbiter_if #(.DW(DW), .AW(AW), .CNTW(CNTW)) bus ();

   grf_wb_arbiter #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   int            mLast;
   logic          mRegWrite;
   logic [AW-1:0] mWa;
   logic [DW-1:0] mWd;
   int            mCnt;
   logic [1:0]    lastGrant;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mLast     = 1;
      mRegWrite = 1'b0;
      mWa       = '0;
      mWd       = '0;
      mCnt      = 0;
   endtask

   // The requester that did not win most recently takes a tie
   function automatic logic [1:0] expectedGrant();
      int nValid;
      if (reset || bus.hold) return 2'b00;
      nValid = int'(bus.req_valid[0]) + int'(bus.req_valid[1]);
      if (nValid == 2) return 2'b01 << (1 - mLast);
      return bus.req_valid;
   endfunction

   task automatic checkModel();
      logic [1:0] g;
      logic       hit1;
      logic       hit2;
      g    = expectedGrant();
      hit1 = mRegWrite && (mWa == bus.RA1) && (bus.RA1 != 0);
      hit2 = mRegWrite && (mWa == bus.RA2) && (bus.RA2 != 0);
      checkOutput("model req_ready", 32'(bus.req_ready), 32'(g));
      checkOutput("model RegWrite", 32'(bus.RegWrite), 32'(mRegWrite));
      checkOutput("model WA", 32'(bus.WA), 32'(mWa));
      checkOutput("model WD", bus.WD, mWd);
      checkOutput("model byp_hit1", 32'(bus.byp_hit1), 32'(hit1));
      checkOutput("model byp_hit2", 32'(bus.byp_hit2), 32'(hit2));
      checkOutput("model byp_data", bus.byp_data, mWd);
      checkOutput("model stall_cnt", 32'(bus.stall_cnt), 32'(mCnt));
   endtask

   // Check at the falling edge, then advance the model across the rising edge
   task automatic cycle();
      logic [1:0]    g;
      int            nLast;
      logic          nRw;
      logic [AW-1:0] nWa;
      logic [DW-1:0] nWd;
      int            nCnt;
      @(negedge clk);
      checkModel();
      g     = expectedGrant();
      nLast = mLast;
      nRw   = 1'b0;
      nWa   = mWa;
      nWd   = mWd;
      nCnt  = mCnt;
      if (g != 2'b00) begin
         nLast = g[1] ? 1 : 0;
         nWa   = g[1] ? bus.req_wa1 : bus.req_wa0;
         nWd   = g[1] ? bus.req_wd1 : bus.req_wd0;
         nRw   = (nWa != 0);
      end
      if (((bus.req_valid & ~g) != 2'b00) && (nCnt < CNT_MAX)) nCnt = nCnt + 1;
      @(posedge clk);
      #1;
      lastGrant = g;
      if (reset) begin
         modelReset();
      end else begin
         mLast     = nLast;
         mRegWrite = nRw;
         mWa       = nWa;
         mWd       = nWd;
         mCnt      = nCnt;
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < 2; i++) begin
         if (!bus.req_valid[i] || lastGrant[i]) begin
            bus.req_valid[i] = ($urandom % 100) < 60;
            if (i == 0) begin
               bus.req_wa0 = AW'($urandom_range(0, 7));
               bus.req_wd0 = $urandom;
            end else begin
               bus.req_wa1 = AW'($urandom_range(0, 7));
               bus.req_wd1 = $urandom;
            end
         end
      end
      bus.hold = ($urandom % 100) < 15;
      bus.RA1  = $urandom_range(0, 1) ? mWa : AW'($urandom_range(0, 7));
      bus.RA2  = AW'($urandom_range(0, 7));
   endtask

   logic [1:0]    tieReady [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [AW-1:0] tieWa    [4] = '{5'd3, 5'd4, 5'd3, 5'd4};

   initial begin
      reset         = 1'b1;
      bus.hold      = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_wa0   = '0;
      bus.req_wd0   = '0;
      bus.req_wa1   = '0;
      bus.req_wd1   = '0;
      bus.RA1       = '0;
      bus.RA2       = '0;
      lastGrant     = 2'b00;
      modelReset();
      repeat (2) cycle();
      reset = 1'b0;
      #1;
      checkOutput("reset RegWrite", 32'(bus.RegWrite), 32'd0);
      checkOutput("reset stall_cnt", 32'(bus.stall_cnt), 32'd0);

      // Single request from the pipeline
      bus.req_valid = 2'b01;
      bus.req_wa0   = 5'd5;
      bus.req_wd0   = 32'h1234;
      #1;
      checkOutput("single ready", 32'(bus.req_ready), 32'h1);
      cycle();
      bus.req_valid = 2'b00;
      #1;
      checkOutput("single RegWrite", 32'(bus.RegWrite), 32'd1);
      checkOutput("single WA", 32'(bus.WA), 32'd5);
      checkOutput("single WD", bus.WD, 32'h1234);
      checkOutput("single stall_cnt", 32'(bus.stall_cnt), 32'd0);

      // Tie with both requesters valid for four cycles after a fresh reset
      reset = 1'b1;
      modelReset();
      cycle();
      reset         = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_wa0   = 5'd3;
      bus.req_wd0   = 32'h3333;
      bus.req_wa1   = 5'd4;
      bus.req_wd1   = 32'h4444;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("tie ready %0d", i), 32'(bus.req_ready), 32'(tieReady[i]));
         cycle();
         checkOutput($sformatf("tie WA %0d", i), 32'(bus.WA), 32'(tieWa[i]));
      end
      bus.req_valid = 2'b00;
      checkOutput("tie stall_cnt", 32'(bus.stall_cnt), 32'd4);

      // Write to register zero completes but does not enable the write
      bus.req_valid = 2'b10;
      bus.req_wa1   = 5'd0;
      bus.req_wd1   = 32'hFFFF;
      bus.RA1       = 5'd0;
      #1;
      checkOutput("zero ready", 32'(bus.req_ready), 32'h2);
      cycle();
      bus.req_valid = 2'b00;
      #1;
      checkOutput("zero RegWrite", 32'(bus.RegWrite), 32'd0);
      checkOutput("zero byp_hit1", 32'(bus.byp_hit1), 32'd0);
      checkOutput("zero WD", bus.WD, 32'hFFFF);

      // Bypass of an in-flight write
      bus.req_valid = 2'b01;
      bus.req_wa0   = 5'd7;
      bus.req_wd0   = 32'hCAFE;
      cycle();
      bus.req_valid = 2'b00;
      bus.RA1       = 5'd7;
      bus.RA2       = 5'd8;
      #1;
      checkOutput("byp hit1", 32'(bus.byp_hit1), 32'd1);
      checkOutput("byp hit2", 32'(bus.byp_hit2), 32'd0);
      checkOutput("byp data", bus.byp_data, 32'hCAFE);

      // Hold for three cycles while a write is still in the stage
      bus.hold      = 1'b1;
      bus.req_valid = 2'b01;
      bus.req_wa0   = 5'd9;
      bus.req_wd0   = 32'h1111;
      #1;
      checkOutput("hold inflight RegWrite", 32'(bus.RegWrite), 32'd1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("hold ready %0d", i), 32'(bus.req_ready), 32'h0);
         cycle();
         checkOutput($sformatf("hold RegWrite %0d", i), 32'(bus.RegWrite), 32'd0);
      end
      checkOutput("hold stall_cnt", 32'(bus.stall_cnt), 32'd7);
      bus.hold = 1'b0;
      #1;
      checkOutput("hold release ready", 32'(bus.req_ready), 32'h1);
      cycle();
      bus.req_valid = 2'b00;

      // Asynchronous reset between edges with a write in the stage
      bus.req_valid = 2'b01;
      bus.req_wa0   = 5'd6;
      bus.req_wd0   = 32'hABCD;
      cycle();
      bus.req_valid = 2'b11;
      bus.req_wa1   = 5'd2;
      bus.req_wd1   = 32'h2222;
      #1;
      checkOutput("pre-reset RegWrite", 32'(bus.RegWrite), 32'd1);
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("async RegWrite", 32'(bus.RegWrite), 32'd0);
      checkOutput("async WA", 32'(bus.WA), 32'd0);
      checkOutput("async WD", bus.WD, 32'd0);
      checkOutput("async stall_cnt", 32'(bus.stall_cnt), 32'd0);
      checkOutput("async ready", 32'(bus.req_ready), 32'h0);
      cycle();
      reset = 1'b0;
      #1;
      checkOutput("post-reset ready", 32'(bus.req_ready), 32'h1);
      cycle();
      bus.req_valid = 2'b10;
      cycle();
      bus.req_valid = 2'b00;

      // Counter saturation with both requesters held off
      bus.hold      = 1'b1;
      bus.req_valid = 2'b11;
      repeat (20) cycle();
      checkOutput("sat stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));
      reset = 1'b1;
      modelReset();
      cycle();
      reset         = 1'b0;
      bus.hold      = 1'b0;
      bus.req_valid = 2'b00;
      lastGrant     = 2'b00;

      // Randomized traffic honouring the hold-until-accepted contract
      for (int n = 0; n < 400; n++) begin
         applyStimulus();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/WA/WD) between two writeback requesters: requester 0 is the main pipeline W stage; requester 1 is the multi-cycle unit (MDU/late load).
- Arbitrates round-robin and registers the winning write into one output stage that drives the register file.
- Provides a bypass for reads that hit the in-flight write.
- Keeps a saturating contention counter for performance debug.

Parameters:
- DW, 32, data width of write data
- AW, 5, register address width
- CNTW, 16, width of contention counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- hold  in  1  suspend arbitration; no request accepted while high
- req_valid  in  2  per-requester write request valid; bit i = requester i
- req_ready  out  2  per-requester grant; handshake completes when valid&ready
- req_wa0  in  AW  requester 0 destination register
- req_wd0  in  DW  requester 0 write data
- req_wa1  in  AW  requester 1 destination register
- req_wd1  in  DW  requester 1 write data
- RegWrite  out  1  write enable to register file (registered)
- WA  out  AW  write address to register file (registered)
- WD  out  DW  write data to register file (registered)
- RA1  in  AW  register-file read address 1 (for bypass compare)
- RA2  in  AW  register-file read address 2
- byp_hit1  out  1  RA1 matches the in-flight write
- byp_hit2  out  1  RA2 matches the in-flight write
- byp_data  out  DW  bypass data (equals WD)
- stall_cnt  out  CNTW  saturating count of denied-request cycles

Behaviour:
- Reset (async, immediate on reset=1): RegWrite=0, WA=0, WD=0, last=1 (requester 0 wins the first tie), stall_cnt=0.
  - req_ready stays combinational and is 0 while reset is asserted.
- Grant (combinational):
  - hold=1 or reset=1: req_ready=00.
  - Only one valid: that requester is granted.
  - Both valid: grant the index != last.
  - At most one bit of req_ready is set.
  - ready depends on valid; valid never depends on ready.
- Requester contract: once valid rises it stays high with stable wa/wd until accepted. The bench checks this; the RTL does not.
- Output stage: updates every rising edge.
  - Accepted request with wa!=0: RegWrite=1, WA/WD=granted wa/wd.
  - Accepted request with wa==0: WA/WD are captured, RegWrite=0. This counts as a completed handshake.
  - No acceptance: RegWrite=0; WA/WD hold their previous values.
- Latency: exactly 1 cycle from accepting edge to RegWrite visible; the register file commits on the following edge.
- Throughput: one write per cycle, no back-pressure from the register file.
- Pointer: last <= granted index on every accepted handshake. It is unchanged on cycles with no grant or with hold.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1… A waiting requester waits at most 1 cycle when hold=0.
- Bypass:
  - byp_hitN = RegWrite & (WA==RAN) & (RAN!=0).
  - byp_data = WD.
  - Purely combinational; covers the cycle where the write is in the stage but not yet in the register file.
- stall_cnt:
  - Increments by 1 per cycle in which any requester is valid and not ready. hold cycles count.
  - If both requesters are denied, it increments by 1, not 2.
  - Saturates at all-ones; cleared only by reset.
- Reset mid-operation: outputs clear immediately and any in-flight write is discarded. A requester still holding valid after reset deasserts is re-arbitrated, and requester 0 wins a tie.
- hold asserted while the stage holds a write: that write still drives the register file for its cycle. The next cycle shows RegWrite=0.

Decomposition:
- Shared package: DW/AW defaults, REG_ZERO constant (5'd0), requester index constants REQ_PIPE=0, REQ_MDU=1.
- One natural sub-module, rr_arb2: the 2-way round-robin grant logic plus the last pointer.
- The output stage, bypass and counter stay in grf_wb_arbiter.

Test Plan:
- Reset then single request: reset pulse, then valid=01, wa0=5, wd0=0x1234 → req_ready=01 that cycle; next cycle RegWrite=1, WA=5, WD=0x1234; stall_cnt=0.
- Tie and alternation: both valid for 4 cycles with wa0=3, wa1=4 → grants 01,10,01,10; WA sequence 3,4,3,4; stall_cnt=4.
- $0 write: valid=10, wa1=0, wd1=0xFFFF → ready=10; next cycle RegWrite=0; byp_hit1=0 with RA1=0.
- Bypass: in-flight write WA=7, WD=0xCAFE, RA1=7, RA2=8 → byp_hit1=1, byp_hit2=0, byp_data=0xCAFE.
- hold: hold=1 for 3 cycles with valid=01 → ready=00, RegWrite=0, stall_cnt +3, last unchanged; on hold release requester 0 is granted.
- Async reset mid-stream: assert reset between edges while RegWrite=1 → RegWrite=0 immediately; after release with both valid, requester 0 is granted first; stall_cnt saturation checked with CNTW=4 (stays at 15).
